bcd_counter_sequencer: RTL and testbench

BCD_COUNTER_SEQUENCER -- requirements
Module: bcd_counter_sequencer

---
 rtl/bcd_pkg.sv | 14 +
 rtl/bcd_digit.sv | 35 +++
 rtl/bcd_counter_sequencer.sv | 109 ++++++++++
 tb/tb_bcd_counter_sequencer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared FSM state encodings and BCD digit constants for the BCD counter sequencer.
package bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_UP    = 2'd1,
    ST_DOWN  = 2'd2,
    ST_PAUSE = 2'd3
  } state_t;

  localparam logic [3:0] BCD_ZERO = 4'd0;
  localparam logic [3:0] BCD_NINE = 4'd9;

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit (0..9) with load, increment and decrement.
// Carry/borrow outputs drive the next digit up the ripple chain.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  input  logic       dec,
  input  logic       load0,
  input  logic       load9,
  output logic [3:0] value,
  output logic       cout,
  output logic       bout
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= BCD_ZERO;
    end else if (load0) begin
      value <= BCD_ZERO;
    end else if (load9) begin
      value <= BCD_NINE;
    end else if (inc) begin
      value <= (value == BCD_NINE) ? BCD_ZERO : value + 4'd1;
    end else if (dec) begin
      value <= (value == BCD_ZERO) ? BCD_NINE : value - 4'd1;
    end
  end

  // A carry/borrow leaves this digit only when it wraps on this step.
  assign cout = inc && (value == BCD_NINE);
  assign bout = dec && (value == BCD_ZERO);

endmodule

// File: rtl/bcd_counter_sequencer.sv
// Button-driven up/down BCD counter: edge-detected commands, a prescaler
// that paces count steps, and a small IDLE/UP/DOWN/PAUSE sequencer.
module bcd_counter_sequencer
  import bcd_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                btn_up,
  input  logic                btn_down,
  input  logic                btn_pause,
  input  logic                btn_set0,
  input  logic                btn_set9,
  output logic [4*DIGITS-1:0] digits,
  output logic [1:0]          state,
  output logic                overflow,
  output logic                underflow
);

  localparam logic [15:0] PRESC_MAX = 16'(TICK_DIV - 1);

  state_t        state_q;
  state_t        dir_q;
  logic [15:0]   presc;
  logic [4:0]    btn_now;
  logic [4:0]    prev;
  logic [4:0]    rise;
  logic          do_set0, do_set9, do_pause, do_down, do_up, cmd_any;
  logic          counting, tick, step_up, step_down;
  logic [DIGITS:0] carry, borrow;

  assign btn_now = {btn_set0, btn_set9, btn_pause, btn_down, btn_up};
  assign rise    = btn_now & ~prev;

  // Previous samples start high so a button held across reset release is not a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev <= '1;
    else        prev <= btn_now;
  end

  // Only the highest-priority press counts; commands that would change nothing are dropped.
  always_comb begin
    do_set0  = rise[4];
    do_set9  = rise[3] && !rise[4];
    do_pause = rise[2] && !(|rise[4:3]) && (state_q != ST_IDLE);
    do_down  = rise[1] && !(|rise[4:2]) && (state_q != ST_DOWN);
    do_up    = rise[0] && !(|rise[4:1]) && (state_q != ST_UP);
    cmd_any  = do_set0 || do_set9 || do_pause || do_down || do_up;
  end

  assign counting  = (state_q == ST_UP) || (state_q == ST_DOWN);
  assign tick      = counting && (presc == PRESC_MAX);
  assign step_up   = tick && !cmd_any && (state_q == ST_UP);
  assign step_down = tick && !cmd_any && (state_q == ST_DOWN);

  assign carry[0]  = step_up;
  assign borrow[0] = step_down;

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    bcd_digit u_digit (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (carry[k]),
      .dec   (borrow[k]),
      .load0 (do_set0),
      .load9 (do_set9),
      .value (digits[4*k +: 4]),
      .cout  (carry[k+1]),
      .bout  (borrow[k+1])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      dir_q     <= ST_UP;
      presc     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= carry[DIGITS];
      underflow <= borrow[DIGITS];
      if (do_set0 || do_set9) begin
        state_q <= ST_IDLE;
        presc   <= '0;
      end else if (do_pause) begin
        if (state_q == ST_PAUSE) begin
          state_q <= dir_q;
        end else begin
          dir_q   <= state_q;
          state_q <= ST_PAUSE;
        end
      end else if (do_down) begin
        state_q <= ST_DOWN;
        presc   <= '0;
      end else if (do_up) begin
        state_q <= ST_UP;
        presc   <= '0;
      end else if (counting) begin
        presc <= tick ? 16'd0 : presc + 16'd1;
      end
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_bcd_counter_sequencer.sv
// Bench for bcd_counter_sequencer: integer-valued behavioural model compared
// every cycle, plus literal checks on the directed scenarios.
module tb_bcd_counter_sequencer;

  localparam int DIGITS   = 4;
  localparam int TICK_DIV = 4;
  localparam int MAXV     = 9999;

  logic                clk = 1'b0;
  logic                rst_n = 1'b1;
  logic                btn_up = 1'b0, btn_down = 1'b0, btn_pause = 1'b0;
  logic                btn_set0 = 1'b0, btn_set9 = 1'b0;
  logic [4*DIGITS-1:0] digits;
  logic [1:0]          state;
  logic                overflow, underflow;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  bcd_counter_sequencer #(.DIGITS(DIGITS), .TICK_DIV(TICK_DIV)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .btn_pause (btn_pause),
    .btn_set0  (btn_set0),
    .btn_set9  (btn_set9),
    .digits    (digits),
    .state     (state),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
    logic [4*DIGITS-1:0] r;
    int t;
    t = v;
    r = '0;
    for (int k = 0; k < DIGITS; k++) begin
      r[4*k +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Behavioural model: value kept as a plain integer, state as 0..3.
  int       m_val = 0, m_state = 0, m_presc = 0, m_dir = 1;
  bit       m_ovf = 0, m_unf = 0, acted;
  logic [4:0] m_prev = '1, m_now, m_rise;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_val = 0; m_state = 0; m_presc = 0; m_dir = 1;
      m_ovf = 0; m_unf = 0; m_prev = '1;
    end else begin
      m_now  = {btn_set0, btn_set9, btn_pause, btn_down, btn_up};
      m_rise = m_now & ~m_prev;
      m_prev = m_now;
      m_ovf = 0; m_unf = 0; acted = 0;
      if (m_rise[4]) begin
        m_val = 0; m_state = 0; m_presc = 0; acted = 1;
      end else if (m_rise[3]) begin
        m_val = MAXV; m_state = 0; m_presc = 0; acted = 1;
      end else if (m_rise[2]) begin
        if (m_state == 3) begin
          m_state = m_dir; acted = 1;
        end else if (m_state != 0) begin
          m_dir = m_state; m_state = 3; acted = 1;
        end
      end else if (m_rise[1]) begin
        if (m_state != 2) begin m_state = 2; m_presc = 0; acted = 1; end
      end else if (m_rise[0]) begin
        if (m_state != 1) begin m_state = 1; m_presc = 0; acted = 1; end
      end
      if (!acted && (m_state == 1 || m_state == 2)) begin
        if (m_presc == TICK_DIV - 1) begin
          m_presc = 0;
          if (m_state == 1) begin
            m_ovf = (m_val == MAXV);
            m_val = (m_val + 1) % (MAXV + 1);
          end else begin
            m_unf = (m_val == 0);
            m_val = (m_val + MAXV) % (MAXV + 1);
          end
        end else begin
          m_presc++;
        end
      end
    end
  end

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check_output("model_digits", int'(digits), int'(to_bcd(m_val)));
      check_output("model_state", int'(state), m_state);
      check_output("model_overflow", int'(overflow), int'(m_ovf));
      check_output("model_underflow", int'(underflow), int'(m_unf));
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive a one-cycle press: idx 0=up 1=down 2=pause 3=set9 4=set0.
  task automatic apply_stimulus(input int idx);
    @(negedge clk);
    case (idx)
      0: btn_up = 1'b1;
      1: btn_down = 1'b1;
      2: btn_pause = 1'b1;
      3: btn_set9 = 1'b1;
      default: btn_set0 = 1'b1;
    endcase
    @(negedge clk);
    btn_up = 1'b0; btn_down = 1'b0; btn_pause = 1'b0;
    btn_set9 = 1'b0; btn_set0 = 1'b0;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    cmp_en = 1'b1;
    idle(3);
    check_output("reset_digits", int'(digits), 0);
    check_output("reset_state", int'(state), 0);
    rst_n = 1'b1;

    // set9 then up: wraps to 0000 after four cycles with one overflow pulse
    apply_stimulus(3);
    check_output("set9_digits", int'(digits), 'h9999);
    apply_stimulus(0);
    check_output("up_state", int'(state), 1);
    idle(3);
    check_output("pre_wrap", int'(digits), 'h9999);
    idle(1);
    check_output("wrap_digits", int'(digits), 'h0000);
    check_output("wrap_overflow", int'(overflow), 1);
    check_output("wrap_state", int'(state), 1);
    idle(1);
    check_output("overflow_clears", int'(overflow), 0);

    // down from 0000: underflow to 9999, then ten more steps
    apply_stimulus(4);
    apply_stimulus(1);
    idle(4);
    check_output("down_wrap", int'(digits), 'h9999);
    check_output("down_underflow", int'(underflow), 1);
    idle(40);
    check_output("down_9989", int'(digits), 'h9989);

    // 0199 -> 0200, pause freezes, resume continues
    apply_stimulus(4);
    apply_stimulus(0);
    idle(796);
    check_output("at_0199", int'(digits), 'h0199);
    idle(4);
    check_output("at_0200", int'(digits), 'h0200);
    apply_stimulus(2);
    check_output("paused_state", int'(state), 3);
    idle(20);
    check_output("paused_value", int'(digits), 'h0200);
    apply_stimulus(2);
    check_output("resumed_state", int'(state), 1);
    idle(4);
    check_output("resumed_step", int'(digits), 'h0201);

    // set0 and up together on a step edge at 0042
    apply_stimulus(4);
    apply_stimulus(0);
    idle(168);
    check_output("at_0042", int'(digits), 'h0042);
    idle(3);
    btn_set0 = 1'b1; btn_up = 1'b1;
    @(negedge clk);
    btn_set0 = 1'b0; btn_up = 1'b0;
    check_output("set0_wins_digits", int'(digits), 'h0000);
    check_output("set0_wins_state", int'(state), 0);

    // up held: one command only, so a pause during the hold sticks
    @(negedge clk);
    btn_up = 1'b1;
    idle(20);
    btn_pause = 1'b1;
    idle(1);
    btn_pause = 1'b0;
    idle(29);
    check_output("held_up_paused", int'(state), 3);
    btn_up = 1'b0;
    apply_stimulus(4);

    // up held through reset release does not fire
    btn_up = 1'b1;
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(10);
    check_output("held_reset_state", int'(state), 0);
    btn_up = 1'b0;

    // asynchronous reset mid-count at 0317
    apply_stimulus(0);
    idle(1268);
    check_output("at_0317", int'(digits), 'h0317);
    #2 rst_n = 1'b0;
    #1;
    check_output("async_digits", int'(digits), 0);
    check_output("async_state", int'(state), 0);
    idle(2);
    rst_n = 1'b1;
    idle(10);
    check_output("post_reset_overflow", int'(overflow), 0);
    check_output("post_reset_digits", int'(digits), 0);

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
